// File: rtl/sig_loader.sv
// Signature loader: streams seed_h then h2 words from a valid/ready input into the
// verifier memories, then starts the verifier and reports its completion.
module sig_loader #(
    parameter string    PARAMETER_SET = "L1",
    localparam int      LAMBDA        = (PARAMETER_SET == "L3") ? 192 :
                                        (PARAMETER_SET == "L5") ? 256 : 128,
    localparam int      SEED_WORDS    = LAMBDA / 32,
    localparam int      H2_WORDS      = (2 * LAMBDA) / 32,
    localparam int      SEED_AW       = $clog2(SEED_WORDS),
    localparam int      H2_AW         = $clog2(H2_WORDS)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [31:0]        i_sig_data,
    input  logic               i_sig_valid,
    output logic               o_sig_ready,
    output logic [31:0]        o_seed_h,
    output logic [SEED_AW-1:0] o_seed_h_addr,
    output logic               o_seed_h_wr_en,
    output logic [31:0]        o_h2,
    output logic [H2_AW-1:0]   o_h2_addr,
    output logic               o_h2_wr_en,
    output logic               o_verify_start,
    input  logic               i_verify_done,
    output logic               o_busy,
    output logic               o_done
);

    // The h2 region is always the larger one, so its address width sizes the counter.
    localparam int                CNT_W     = H2_AW;
    localparam logic [CNT_W-1:0]  SEED_LAST = CNT_W'(SEED_WORDS - 1);
    localparam logic [CNT_W-1:0]  H2_LAST   = CNT_W'(H2_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_SEED = 3'd1,
        S_LOAD_H2   = 3'd2,
        S_START     = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [31:0]          seed_data_q, seed_data_d;
    logic [SEED_AW-1:0]   seed_addr_q, seed_addr_d;
    logic                 seed_we_q, seed_we_d;
    logic [31:0]          h2_data_q, h2_data_d;
    logic [H2_AW-1:0]     h2_addr_q, h2_addr_d;
    logic                 h2_we_q, h2_we_d;
    logic                 start_q, start_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ready_s;
    logic                 xfer_s;

    // Ready is a pure state decode so the upstream sees it without a cycle of lag.
    always_comb begin
        ready_s = 1'b0;
        if ((state_q == S_LOAD_SEED) || (state_q == S_LOAD_H2)) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
    end

    assign xfer_s = i_sig_valid & ready_s;

    // Next-state, counter and write-port computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        seed_data_d = seed_data_q;
        seed_addr_d = seed_addr_q;
        seed_we_d   = 1'b0;
        h2_data_d   = h2_data_q;
        h2_addr_d   = h2_addr_q;
        h2_we_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (i_load) begin
                    state_d = S_LOAD_SEED;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD_SEED: begin
                if (xfer_s) begin
                    seed_data_d = i_sig_data;
                    seed_addr_d = cnt_q[SEED_AW-1:0];
                    seed_we_d   = 1'b1;
                    if (cnt_q == SEED_LAST) begin
                        cnt_d   = '0;
                        state_d = S_LOAD_H2;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = S_LOAD_SEED;
                    end
                end else begin
                    state_d = S_LOAD_SEED;
                end
            end
            S_LOAD_H2: begin
                if (xfer_s) begin
                    h2_data_d = i_sig_data;
                    h2_addr_d = cnt_q;
                    h2_we_d   = 1'b1;
                    if (cnt_q == H2_LAST) begin
                        cnt_d   = '0;
                        state_d = S_START;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = S_LOAD_H2;
                    end
                end else begin
                    state_d = S_LOAD_H2;
                end
            end
            S_START: begin
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i_verify_done) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Status flags are registered from the next state so they match the state exactly.
    always_comb begin
        start_d = (state_d == S_START);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            seed_data_q <= 32'd0;
            seed_addr_q <= '0;
            seed_we_q   <= 1'b0;
            h2_data_q   <= 32'd0;
            h2_addr_q   <= '0;
            h2_we_q     <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seed_data_q <= seed_data_d;
            seed_addr_q <= seed_addr_d;
            seed_we_q   <= seed_we_d;
            h2_data_q   <= h2_data_d;
            h2_addr_q   <= h2_addr_d;
            h2_we_q     <= h2_we_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign o_sig_ready    = ready_s;
    assign o_seed_h       = seed_data_q;
    assign o_seed_h_addr  = seed_addr_q;
    assign o_seed_h_wr_en = seed_we_q;
    assign o_h2           = h2_data_q;
    assign o_h2_addr      = h2_addr_q;
    assign o_h2_wr_en     = h2_we_q;
    assign o_verify_start = start_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;

endmodule
